// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and defaults for the PISO transmitter family
package piso_pkg;

   typedef enum logic [1:0] {
      PISO_IDLE   = 2'd0,
      PISO_SHIFT  = 2'd1,
      PISO_PARITY = 2'd2
   } piso_state_e;

   localparam int PISO_WIDTH_DEF = 32;
   localparam int PISO_CNT_W     = $clog2(PISO_WIDTH_DEF);

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - beat counter for bit-serial blocks; last flags the final beat of a WIDTH-bit word
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_WIDTH_DEF,
   parameter int CNT_W = PISO_CNT_W
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   // clr wins over inc so the final beat returns the counter to zero rather than wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

   assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_shift_register_32bit.sv
// rtl/piso_shift_register_32bit.sv - MSB-first parallel-in serial-out transmitter with load handshake
// Define PISO_PARITY_EN to append one even-parity beat after the data word.
module piso_shift_register_32bit
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_WIDTH_DEF
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH);

   piso_state_e      state;
   logic [WIDTH-1:0] sreg;
   logic [CNT_W-1:0] beat_cnt;
   logic             beat_last;
   logic             accept;
   logic             shift_beat;
   logic             cnt_clr;

   assign accept     = (state == PISO_IDLE) && load_valid;
   assign shift_beat = (state == PISO_SHIFT) && en;
   assign cnt_clr    = (state == PISO_IDLE) || (shift_beat && beat_last);

   piso_bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (shift_beat),
      .count (beat_cnt),
      .last  (beat_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= PISO_IDLE;
         sreg  <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            PISO_IDLE: begin
               if (load_valid) begin
                  sreg  <= load_data;
                  state <= PISO_SHIFT;
               end
            end
            PISO_SHIFT: begin
               if (en) begin
                  sreg <= {sreg[WIDTH-2:0], 1'b0};
                  if (beat_last) begin
`ifdef PISO_PARITY_EN
                     state <= PISO_PARITY;
`else
                     state <= PISO_IDLE;
                     done  <= 1'b1;
`endif
                  end
               end
            end
`ifdef PISO_PARITY_EN
            PISO_PARITY: begin
               if (en) begin
                  state <= PISO_IDLE;
                  done  <= 1'b1;
               end
            end
`endif
            default: state <= PISO_IDLE;
         endcase
      end
   end

`ifdef PISO_PARITY_EN
   // parity is taken from the word as loaded, since sreg has been shifted empty by the parity beat
   logic parity_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_bit <= 1'b0;
      end else if (accept) begin
         parity_bit <= ^load_data;
      end
   end

   always_comb begin
      serial_out = 1'b0;
      case (state)
         PISO_SHIFT:  serial_out = sreg[WIDTH-1];
         PISO_PARITY: serial_out = parity_bit;
         default:     serial_out = 1'b0;
      endcase
   end
`else
   always_comb begin
      serial_out = 1'b0;
      if (state == PISO_SHIFT) begin
         serial_out = sreg[WIDTH-1];
      end
   end
`endif

   assign load_ready   = (state == PISO_IDLE);
   assign busy         = (state != PISO_IDLE);
   assign serial_valid = busy && en;

   // the counter must sit at zero whenever no frame is in flight
   a_cnt_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
      (state == PISO_IDLE) |-> (beat_cnt == '0));

   logic unused_accept;
   assign unused_accept = accept;

endmodule
